// File: rtl/noekeon_pkg.sv
// Shared constants and state encoding for the Noekeon host word adapter.
package noekeon_pkg;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 128;
    localparam int WORDS   = BLOCK_W / WORD_W;
    localparam int CNT_W   = $clog2(WORDS);

    localparam logic MODE_DIRECT   = 1'b0;
    localparam logic MODE_INDIRECT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_WAIT_KEY = 3'd3,
        ST_WAIT_RES = 3'd4,
        ST_CAPTURE  = 3'd5,
        ST_DRAIN    = 3'd6
    } state_e;

endpackage

// File: rtl/noekeon_word_shift.sv
// Block-wide register with parallel load and word-granular left shift.
// OUT_W selects how many of the top bits are exposed (whole block or top word).
module noekeon_word_shift #(
    parameter int BLOCK_W = 128,
    parameter int WORD_W  = 32,
    parameter int OUT_W   = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_en,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic               shift_en,
    input  logic [WORD_W-1:0]  shift_in,
    output logic [OUT_W-1:0]   q
);

    logic [BLOCK_W-1:0] block_q;
    logic [BLOCK_W-1:0] block_d;

    always_comb begin
        block_d = block_q;
        if (load_en) begin
            block_d = load_data;
        end else if (shift_en) begin
            block_d = {block_q[BLOCK_W-WORD_W-1:0], shift_in};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            block_q <= '0;
        end else begin
            block_q <= block_d;
        end
    end

    assign q = block_q[BLOCK_W-1 -: OUT_W];

endmodule

// File: rtl/noekeon_word_if.sv
// Host word adapter for the Noekeon core: assembles key/data blocks from
// 32-bit words, issues one write strobe, then streams the result back.
module noekeon_word_if #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 128
) (
    input  logic               inClk,
    input  logic               inReset,
    input  logic               inWrValid,
    output logic               outWrReady,
    input  logic [WORD_W-1:0]  inWrData,
    input  logic               inWrKey,
    input  logic               inWrMode,
    input  logic               inWrDecipher,
    output logic [BLOCK_W-1:0] outCoreBlock,
    output logic               outCoreKeyWr,
    output logic               outCoreDataWr,
    output logic               outCoreMode,
    output logic               outCoreDecipher,
    input  logic               inCoreBusy,
    input  logic               inCoreResultWr,
    input  logic [BLOCK_W-1:0] inCoreResult,
    output logic               outRdValid,
    input  logic               inRdReady,
    output logic [WORD_W-1:0]  outRdData,
    output logic               outIdle
);

    import noekeon_pkg::*;

    localparam int N_WORDS  = BLOCK_W / WORD_W;
    localparam int CNT_BITS = $clog2(N_WORDS);
    localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(N_WORDS - 1);

    state_e              state_q, state_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                key_q, key_d;
    logic                mode_q, mode_d;
    logic                dec_q, dec_d;

    logic                asm_load;
    logic [BLOCK_W-1:0]  asm_load_data;
    logic [BLOCK_W-1:0]  asm_block;
    logic                res_load;
    logic                res_shift;
    logic [WORD_W-1:0]   res_word;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_d         = key_q;
        mode_d        = mode_q;
        dec_d         = dec_q;
        asm_load      = 1'b0;
        asm_load_data = asm_block;
        res_load      = 1'b0;
        res_shift     = 1'b0;
        outCoreKeyWr  = 1'b0;
        outCoreDataWr = 1'b0;
        outRdValid    = 1'b0;

        // Drop the incoming word into the slot selected by the counter.
        for (int i = 0; i < N_WORDS; i++) begin
            if (cnt_q == CNT_BITS'(i)) begin
                asm_load_data[BLOCK_W-1-i*WORD_W -: WORD_W] = inWrData;
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (inWrValid) begin
                    asm_load      = 1'b1;
                    asm_load_data = {inWrData, {(BLOCK_W-WORD_W){1'b0}}};
                    key_d         = inWrKey;
                    mode_d        = inWrMode;
                    dec_d         = inWrDecipher;
                    cnt_d         = CNT_BITS'(1);
                    state_d       = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (inWrValid) begin
                    asm_load = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_ISSUE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (!inCoreBusy) begin
                    outCoreKeyWr  = key_q;
                    outCoreDataWr = !key_q;
                    cnt_d         = '0;
                    if (!key_q) begin
                        state_d = ST_WAIT_RES;
                    end else if (mode_q == MODE_INDIRECT) begin
                        state_d = ST_WAIT_KEY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_KEY: begin
                // The core raises busy one cycle after the strobe, so the
                // first cycle here is skipped using the counter as a flag.
                if (cnt_q == '0) begin
                    cnt_d = CNT_BITS'(1);
                end else if (!inCoreBusy) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RES: begin
                if (inCoreResultWr) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                res_load = 1'b1;
                cnt_d    = '0;
                state_d  = ST_DRAIN;
            end
            ST_DRAIN: begin
                outRdValid = 1'b1;
                if (inRdReady) begin
                    res_shift = 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge inClk or posedge inReset) begin
        if (inReset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            key_q   <= 1'b0;
            mode_q  <= 1'b0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            key_q   <= key_d;
            mode_q  <= mode_d;
            dec_q   <= dec_d;
        end
    end

    noekeon_word_shift #(
        .BLOCK_W (BLOCK_W),
        .WORD_W  (WORD_W),
        .OUT_W   (BLOCK_W)
    ) u_assembler (
        .clk       (inClk),
        .rst       (inReset),
        .load_en   (asm_load),
        .load_data (asm_load_data),
        .shift_en  (1'b0),
        .shift_in  ({WORD_W{1'b0}}),
        .q         (asm_block)
    );

    noekeon_word_shift #(
        .BLOCK_W (BLOCK_W),
        .WORD_W  (WORD_W),
        .OUT_W   (WORD_W)
    ) u_result (
        .clk       (inClk),
        .rst       (inReset),
        .load_en   (res_load),
        .load_data (inCoreResult),
        .shift_en  (res_shift),
        .shift_in  ({WORD_W{1'b0}}),
        .q         (res_word)
    );

    assign outWrReady      = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign outIdle         = (state_q == ST_IDLE);
    assign outCoreBlock    = asm_block;
    assign outCoreMode     = mode_q;
    assign outCoreDecipher = dec_q;
    assign outRdData       = res_word;

    // Result strobes arriving outside WAIT_RES are tracked but never acted on.
    cover property (@(posedge inClk) disable iff (inReset)
        inCoreResultWr && (state_q != ST_WAIT_RES));

endmodule

// File: tb/tb_noekeon_word_if.sv
// Directed bench for noekeon_word_if: table of bursts plus reset and stray-strobe sequences.
module tb_noekeon_word_if;

    logic         inClk = 1'b0;
    logic         inReset;
    logic         inWrValid;
    logic         outWrReady;
    logic [31:0]  inWrData;
    logic         inWrKey;
    logic         inWrMode;
    logic         inWrDecipher;
    logic [127:0] outCoreBlock;
    logic         outCoreKeyWr;
    logic         outCoreDataWr;
    logic         outCoreMode;
    logic         outCoreDecipher;
    logic         inCoreBusy;
    logic         inCoreResultWr;
    logic [127:0] inCoreResult;
    logic         outRdValid;
    logic         inRdReady;
    logic [31:0]  outRdData;
    logic         outIdle;

    always #5 inClk = ~inClk;

    noekeon_word_if dut (
        .inClk           (inClk),
        .inReset         (inReset),
        .inWrValid       (inWrValid),
        .outWrReady      (outWrReady),
        .inWrData        (inWrData),
        .inWrKey         (inWrKey),
        .inWrMode        (inWrMode),
        .inWrDecipher    (inWrDecipher),
        .outCoreBlock    (outCoreBlock),
        .outCoreKeyWr    (outCoreKeyWr),
        .outCoreDataWr   (outCoreDataWr),
        .outCoreMode     (outCoreMode),
        .outCoreDecipher (outCoreDecipher),
        .inCoreBusy      (inCoreBusy),
        .inCoreResultWr  (inCoreResultWr),
        .inCoreResult    (inCoreResult),
        .outRdValid      (outRdValid),
        .inRdReady       (inRdReady),
        .outRdData       (outRdData),
        .outIdle         (outIdle)
    );

    typedef struct packed {
        logic             key;
        logic             mode;
        logic             dec;
        logic [7:0]       busy_hold;
        logic [15:0]      ready_pat;
        logic [3:0][31:0] words;
        logic [127:0]     exp_block;
        logic [127:0]     result;
        logic [3:0][31:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    int n_vec = 0;
    int n_err = 0;

    int           key_strobes  = 0;
    int           data_strobes = 0;
    int           rdv_cycles   = 0;
    logic [127:0] strobe_block = '0;
    logic         strobe_mode  = 1'b0;
    logic         strobe_dec   = 1'b0;

    always @(posedge inClk) begin
        if (outCoreKeyWr) begin
            key_strobes  <= key_strobes + 1;
            strobe_block <= outCoreBlock;
            strobe_mode  <= outCoreMode;
            strobe_dec   <= outCoreDecipher;
        end
        if (outCoreDataWr) begin
            data_strobes <= data_strobes + 1;
            strobe_block <= outCoreBlock;
            strobe_mode  <= outCoreMode;
            strobe_dec   <= outCoreDecipher;
        end
        if (outRdValid) begin
            rdv_cycles <= rdv_cycles + 1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic k, input logic m, input logic d,
                                input int bh, input logic [15:0] rp,
                                input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [31:0] w3,
                                input logic [127:0] eb, input logic [127:0] res,
                                input logic [31:0] r0, input logic [31:0] r1,
                                input logic [31:0] r2, input logic [31:0] r3);
        vec_t v;
        v.key       = k;
        v.mode      = m;
        v.dec       = d;
        v.busy_hold = 8'(bh);
        v.ready_pat = rp;
        v.words[0]  = w0;
        v.words[1]  = w1;
        v.words[2]  = w2;
        v.words[3]  = w3;
        v.exp_block = eb;
        v.result    = res;
        v.exp_rd[0] = r0;
        v.exp_rd[1] = r1;
        v.exp_rd[2] = r2;
        v.exp_rd[3] = r3;
        return v;
    endfunction

    // Offer one word; returns at the negedge after it was accepted.
    task automatic send_word(input logic [31:0] d, input logic k, input logic m, input logic dc);
        int t = 0;
        inWrValid    = 1'b1;
        inWrData     = d;
        inWrKey      = k;
        inWrMode     = m;
        inWrDecipher = dc;
        #1;
        while (!outWrReady && t < 200) begin
            @(negedge inClk);
            #1;
            t++;
        end
        if (!outWrReady) check("wr_ready_timeout", outWrReady, 1'b1);
        @(negedge inClk);
        inWrValid = 1'b0;
    endtask

    // Qualifiers are inverted after word 0 to confirm they are ignored there.
    task automatic send_block(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            if (i == 0) send_word(v.words[i], v.key, v.mode, v.dec);
            else        send_word(v.words[i], ~v.key, ~v.mode, ~v.dec);
        end
    endtask

    // Core model: busy for 17 cycles, result strobe, output register valid afterwards.
    // Returns at the negedge of the first DRAIN cycle.
    task automatic core_result(input logic [127:0] res);
        inCoreBusy = 1'b1;
        repeat (17) @(negedge inClk);
        inCoreBusy     = 1'b0;
        inCoreResultWr = 1'b1;
        inCoreResult   = ~res;
        @(negedge inClk);
        inCoreResultWr = 1'b0;
        inCoreResult   = res;
        #1;
        check("rd_valid_capture_cycle", outRdValid, 1'b0);
        @(negedge inClk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, outWrReady, 1'b1);
        check({tag, "_idle"}, outIdle, 1'b1);
        check({tag, "_strobes"}, {outCoreKeyWr, outCoreDataWr}, 2'b00);
        check({tag, "_rd_valid"}, outRdValid, 1'b0);
        check({tag, "_rd_data"}, outRdData, 32'h0);
        check({tag, "_block"}, outCoreBlock, 128'h0);
        check({tag, "_mode_dec"}, {outCoreMode, outCoreDecipher}, 2'b00);
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        int ks0 = key_strobes;
        int ds0 = data_strobes;
        int rv0 = rdv_cycles;
        int got = 0;
        int p   = 0;
        int t   = 0;
        inCoreBusy = (v.busy_hold != 0);
        send_block(v);
        for (int i = 0; i < int'(v.busy_hold); i++) begin
            #1;
            check({tag, "_no_strobe_busy"}, {outCoreKeyWr, outCoreDataWr}, 2'b00);
            @(negedge inClk);
        end
        inCoreBusy = 1'b0;
        #1;
        check({tag, "_strobe_in_issue"}, {outCoreKeyWr, outCoreDataWr}, {v.key, ~v.key});
        @(negedge inClk);
        check({tag, "_key_strobes"}, key_strobes - ks0, v.key ? 1 : 0);
        check({tag, "_data_strobes"}, data_strobes - ds0, v.key ? 0 : 1);
        check({tag, "_strobe_block"}, strobe_block, v.exp_block);
        if (v.key) check({tag, "_strobe_mode"}, strobe_mode, v.mode);
        else       check({tag, "_strobe_dec"}, strobe_dec, v.dec);

        if (v.key && !v.mode) begin
            #1;
            check({tag, "_idle_after_key"}, outIdle, 1'b1);
        end else if (v.key) begin
            #1;
            check({tag, "_wr_ready_wait0"}, outWrReady, 1'b0);
            @(negedge inClk);
            inCoreBusy = 1'b1;
            for (int i = 0; i < 5; i++) begin
                #1;
                check({tag, "_wr_ready_busy"}, outWrReady, 1'b0);
                @(negedge inClk);
            end
            inCoreBusy = 1'b0;
            #1;
            check({tag, "_wr_ready_drop"}, outWrReady, 1'b0);
            @(negedge inClk);
            #1;
            check({tag, "_idle_after_busy"}, {outIdle, outWrReady}, 2'b11);
        end else begin
            core_result(v.result);
            while (got < 4 && t < 64) begin
                inRdReady = v.ready_pat[p % 16];
                p++;
                #1;
                check({tag, "_rd_valid"}, outRdValid, 1'b1);
                check({tag, "_rd_data"}, outRdData, v.exp_rd[got]);
                if (inRdReady) got++;
                @(negedge inClk);
                t++;
            end
            inRdReady = 1'b0;
            if (got < 4) check({tag, "_drain_timeout"}, got, 4);
            #1;
            check({tag, "_idle_after_drain"}, {outIdle, outRdValid}, 2'b10);
            check({tag, "_dec_held"}, outCoreDecipher, v.dec);
        end
        check({tag, "_block_held"}, outCoreBlock, v.exp_block);
        if (v.key) check({tag, "_no_rd_valid"}, rdv_cycles - rv0, 0);
        @(negedge inClk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ks0;
        int ds0;
        int rv0;

        vecs[0] = mk(1'b1, 1'b0, 1'b0, 0, 16'hFFFF,
                     32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F,
                     128'h00010203_04050607_08090A0B_0C0D0E0F, 128'h0,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[1] = mk(1'b0, 1'b0, 1'b0, 0, 16'hFFFF,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                     128'h11223344_55667788_99AABBCC_DDEEFF00,
                     32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
        vecs[2] = mk(1'b0, 1'b0, 1'b0, 0, 16'h9999,
                     32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                     128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
                     128'h11223344_55667788_99AABBCC_DDEEFF00,
                     32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00);
        vecs[3] = mk(1'b0, 1'b0, 1'b0, 5, 16'hFFFF,
                     32'h89ABCDEF, 32'h01234567, 32'h76543210, 32'hFEDCBA98,
                     128'h89ABCDEF_01234567_76543210_FEDCBA98,
                     128'h01234567_89ABCDEF_00112233_44556677,
                     32'h01234567, 32'h89ABCDEF, 32'h00112233, 32'h44556677);
        vecs[4] = mk(1'b1, 1'b1, 1'b0, 0, 16'hFFFF,
                     32'hDEADBEEF, 32'hCAFEBABE, 32'h0BADF00D, 32'h12345678,
                     128'hDEADBEEF_CAFEBABE_0BADF00D_12345678, 128'h0,
                     32'h0, 32'h0, 32'h0, 32'h0);
        vecs[5] = mk(1'b0, 1'b0, 1'b1, 0, 16'h5555,
                     32'h00000000, 32'h00000001, 32'h80000000, 32'h7FFFFFFF,
                     128'h00000000_00000001_80000000_7FFFFFFF,
                     128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0,
                     32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0);

        inReset        = 1'b1;
        inWrValid      = 1'b0;
        inWrData       = '0;
        inWrKey        = 1'b0;
        inWrMode       = 1'b0;
        inWrDecipher   = 1'b0;
        inCoreBusy     = 1'b0;
        inCoreResultWr = 1'b0;
        inCoreResult   = '0;
        inRdReady      = 1'b0;
        repeat (2) @(negedge inClk);
        #1;
        check_reset_outputs("por");
        @(negedge inClk);
        inReset = 1'b0;
        @(negedge inClk);

        for (int i = 0; i < 6; i++) begin
            $display("vector %0d: key=%0b mode=%0b dec=%0b busy_hold=%0d", i,
                     vecs[i].key, vecs[i].mode, vecs[i].dec, vecs[i].busy_hold);
            run_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Result strobe while idle must be ignored.
        rv0 = rdv_cycles;
        inCoreResultWr = 1'b1;
        inCoreResult   = 128'hCAFE;
        @(negedge inClk);
        inCoreResultWr = 1'b0;
        repeat (4) @(negedge inClk);
        #1;
        check("stray_result_rd_valid", rdv_cycles - rv0, 0);
        check("stray_result_idle", outIdle, 1'b1);
        @(negedge inClk);

        // Reset after two words of a data burst.
        ks0 = key_strobes;
        ds0 = data_strobes;
        send_word(32'hAAAA5555, 1'b0, 1'b0, 1'b1);
        send_word(32'h5555AAAA, 1'b0, 1'b0, 1'b1);
        #1;
        inReset = 1'b1;
        #1;
        check_reset_outputs("rst_load");
        @(negedge inClk);
        inReset = 1'b0;
        repeat (6) @(negedge inClk);
        check("rst_load_no_strobe", (key_strobes - ks0) + (data_strobes - ds0), 0);
        $display("reset during LOAD done");

        // Reset while the second result word is on offer.
        send_block(vecs[1]);
        @(negedge inClk);
        core_result(vecs[1].result);
        inRdReady = 1'b1;
        #1;
        check("rst_drain_word0", outRdData, 32'h11223344);
        @(negedge inClk);
        inRdReady = 1'b0;
        #1;
        check("rst_drain_word1", {outRdValid, outRdData}, {1'b1, 32'h55667788});
        rv0 = rdv_cycles;
        ks0 = key_strobes;
        ds0 = data_strobes;
        inReset = 1'b1;
        #1;
        check_reset_outputs("rst_drain");
        @(negedge inClk);
        inReset = 1'b0;
        repeat (6) @(negedge inClk);
        check("rst_drain_no_rd_valid", rdv_cycles - rv0, 0);
        check("rst_drain_no_strobe", (key_strobes - ks0) + (data_strobes - ds0), 0);
        $display("reset during DRAIN done");

        run_txn("post_reset", vecs[1]);
        $display("post-reset burst done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
